// File: rtl/snn_pkg.sv
// Shared types for the spiking-network step scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

    localparam int TA = 2;
    localparam int N  = 16;
    localparam int NW = $clog2(N);

    typedef struct packed {
        logic [TA-1:0] blk;
        logic [NW-1:0] nrn;
        logic          last;
    } stim_t;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        STEP,
        SETTLE
    } sched_state_t;

endpackage

// File: rtl/snn_stim_fifo.sv
// Synchronous FIFO of stimulus entries with flush.
// Latency: 1 cycle push-to-visible at dout; dout shows the head combinationally.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over push.
module snn_stim_fifo
    import snn_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  stim_t din,
    output logic  full,
    output logic  empty,
    output stim_t dout
);

    localparam int AW = $clog2(DEPTH);

    stim_t         mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/snn_step_scheduler.sv
// Runs the network through num_steps time steps: replay stimulus, strobe time_step, await drain.
// Latency: FIFO pop to force_spike_en 1 cycle; last entry to time_step 2 cycles.
// Backpressure: stim_ready = !fifo_full; injection stalls while the FIFO is empty.
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int STEP_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic              stim_valid,
    output logic              stim_ready,
    input  logic [TA-1:0]     stim_block,
    input  logic [NW-1:0]     stim_neuron,
    input  logic              stim_last,
    input  logic              drain_done,
    output logic              force_spike_en,
    output logic [TA-1:0]     force_spike_block_select,
    output logic [NW-1:0]     force_spike_neuron_select,
    output logic              time_step,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_count,
    output logic              timeout_err
);

    localparam int                CNT_W       = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX    = '1;

    sched_state_t      state;
    logic [STEP_W-1:0] num_steps_q;
    logic [CNT_W-1:0]  settle_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    stim_t             fifo_din;
    stim_t             fifo_dout;

    assign stim_ready = !fifo_full;
    assign fifo_din   = {stim_block, stim_neuron, stim_last};
    assign fifo_pop   = (state == INJECT) && !fifo_empty && !abort;
    assign busy       = (state != IDLE);

    snn_stim_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stim_valid),
        .pop   (fifo_pop),
        .flush (abort),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            num_steps_q               <= '0;
            settle_cnt                <= '0;
            force_spike_en            <= 1'b0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            time_step                 <= 1'b0;
            done                      <= 1'b0;
            step_count                <= '0;
            timeout_err               <= 1'b0;
        end else begin
            force_spike_en            <= 1'b0;
            force_spike_block_select  <= '0;
            force_spike_neuron_select <= '0;
            time_step                 <= 1'b0;
            done                      <= 1'b0;
            // Abort drops every strobe that would otherwise register on this edge.
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            step_count  <= '0;
                            timeout_err <= 1'b0;
                            num_steps_q <= num_steps;
                            if (num_steps == '0) done  <= 1'b1;
                            else                 state <= INJECT;
                        end
                    end
                    INJECT: begin
                        if (fifo_pop) begin
                            force_spike_en            <= 1'b1;
                            force_spike_block_select  <= fifo_dout.blk;
                            force_spike_neuron_select <= fifo_dout.nrn;
                            if (fifo_dout.last) state <= STEP;
                        end
                    end
                    STEP: begin
                        time_step  <= 1'b1;
                        settle_cnt <= '0;
                        if (step_count != STEP_MAX) step_count <= step_count + 1'b1;
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (drain_done || (settle_cnt == SETTLE_LAST)) begin
                            if (!drain_done) timeout_err <= 1'b1;
                            if (step_count == num_steps_q) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= INJECT;
                            end
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: hand-derived strobe timing, timeout, fill, abort, reset.
module tb_snn_step_scheduler;
    import snn_pkg::*;

    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [STEP_W-1:0] num_steps;
    logic              stim_valid;
    logic              stim_ready;
    logic [TA-1:0]     stim_block;
    logic [NW-1:0]     stim_neuron;
    logic              stim_last;
    logic              drain_done;
    logic              force_spike_en;
    logic [TA-1:0]     force_spike_block_select;
    logic [NW-1:0]     force_spike_neuron_select;
    logic              time_step;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_count;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    int ev_kind [64];
    int ev_blk  [64];
    int ev_nrn  [64];
    int ev_cyc  [64];
    int nev;
    int overlap;
    int done_cyc;
    int rdy_c1;

    always #5 clk = ~clk;

    snn_step_scheduler #(
        .FIFO_DEPTH    (16),
        .SETTLE_CYCLES (64),
        .STEP_W        (STEP_W)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .abort                     (abort),
        .num_steps                 (num_steps),
        .stim_valid                (stim_valid),
        .stim_ready                (stim_ready),
        .stim_block                (stim_block),
        .stim_neuron               (stim_neuron),
        .stim_last                 (stim_last),
        .drain_done                (drain_done),
        .force_spike_en            (force_spike_en),
        .force_spike_block_select  (force_spike_block_select),
        .force_spike_neuron_select (force_spike_neuron_select),
        .time_step                 (time_step),
        .busy                      (busy),
        .done                      (done),
        .step_count                (step_count),
        .timeout_err               (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int n, input bit l);
        stim_valid  = 1'b1;
        stim_block  = TA'(b);
        stim_neuron = NW'(n);
        stim_last   = l;
        tick();
        stim_valid  = 1'b0;
    endtask

    task automatic kick(input int ns);
        start     = 1'b1;
        num_steps = STEP_W'(ns);
        tick();
        start     = 1'b0;
    endtask

    // kind 0 = force strobe, kind 1 = time_step; cycle 1 is the first edge after the call.
    task automatic run(input int drain_dly, input int limit);
        int ts_cyc;
        ts_cyc   = -1000;
        nev      = 0;
        overlap  = 0;
        done_cyc = -1;
        rdy_c1   = -1;
        for (int i = 0; i < 64; i++) begin
            ev_kind[i] = -1; ev_blk[i] = -1; ev_nrn[i] = -1; ev_cyc[i] = -1;
        end
        for (int c = 1; c <= limit; c++) begin
            tick();
            drain_done = 1'b0;
            if (c == 1) rdy_c1 = int'(stim_ready);
            if (force_spike_en && nev < 64) begin
                ev_kind[nev] = 0;
                ev_blk[nev]  = int'(force_spike_block_select);
                ev_nrn[nev]  = int'(force_spike_neuron_select);
                ev_cyc[nev]  = c;
                nev++;
            end
            if (time_step) begin
                if (force_spike_en) overlap++;
                if (nev < 64) begin
                    ev_kind[nev] = 1; ev_blk[nev] = 0; ev_nrn[nev] = 0; ev_cyc[nev] = c;
                    nev++;
                end
                ts_cyc = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (drain_dly > 0 && c == ts_cyc + drain_dly) drain_done = 1'b1;
        end
        drain_done = 1'b0;
    endtask

    task automatic ev_is(input string tag, input int i, input int k, input int b, input int n, input int c);
        check($sformatf("%s.kind", tag), ev_kind[i], k);
        check($sformatf("%s.blk", tag),  ev_blk[i],  b);
        check($sformatf("%s.nrn", tag),  ev_nrn[i],  n);
        check($sformatf("%s.cyc", tag),  ev_cyc[i],  c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_steps = '0;
        stim_valid = 1'b0; stim_block = '0; stim_neuron = '0; stim_last = 1'b0;
        drain_done = 1'b0;
        tick(); tick();
        check("rst.en", force_spike_en, 0);
        check("rst.ts", time_step, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.cnt", step_count, 0);
        check("rst.terr", timeout_err, 0);
        check("rst.rdy", stim_ready, 1);
        reset = 1'b0;
        tick();

        // Two steps, drain four cycles after each time_step.
        push(1, 5, 0); push(2, 7, 1); push(0, 3, 1);
        kick(2);
        check("t2.busy", busy, 1);
        run(4, 100);
        check("t2.nev", nev, 5);
        ev_is("t2.e0", 0, 0, 1, 5, 1);
        ev_is("t2.e1", 1, 0, 2, 7, 2);
        ev_is("t2.e2", 2, 1, 0, 0, 3);
        ev_is("t2.e3", 3, 0, 0, 3, 9);
        ev_is("t2.e4", 4, 1, 0, 0, 10);
        check("t2.done_cyc", done_cyc, 15);
        check("t2.cnt", step_count, 2);
        check("t2.terr", timeout_err, 0);
        check("t2.overlap", overlap, 0);
        check("t2.busy_end", busy, 0);
        tick();
        check("t2.done_pulse", done, 0);

        // No drain: SETTLE times out 64 cycles after time_step.
        push(3, 15, 1);
        kick(1);
        run(0, 100);
        ev_is("t3.e0", 0, 0, 3, 15, 1);
        ev_is("t3.e1", 1, 1, 0, 0, 2);
        check("t3.done_cyc", done_cyc, 66);
        check("t3.terr", timeout_err, 1);
        check("t3.cnt", step_count, 1);
        check("t3.busy", busy, 0);

        // Zero-length run.
        kick(0);
        check("t4.done", done, 1);
        check("t4.busy", busy, 0);
        check("t4.cnt", step_count, 0);
        check("t4.terr", timeout_err, 0);
        tick();
        check("t4.done2", done, 0);
        check("t4.busy2", busy, 0);
        check("t4.en", force_spike_en, 0);

        // Fill the FIFO while IDLE, then drain one entry per cycle.
        for (int i = 0; i < 16; i++) begin
            push(i % 4, i, i == 15);
            if (i == 14) check("t5.rdy15", stim_ready, 1);
        end
        check("t5.rdy16", stim_ready, 0);
        kick(1);
        check("t5.rdy_start", stim_ready, 0);
        run(2, 100);
        check("t5.rdy_c1", rdy_c1, 1);
        check("t5.nev", nev, 17);
        for (int i = 0; i < 16; i++) ev_is($sformatf("t5.e%0d", i), i, 0, i % 4, i, i + 1);
        ev_is("t5.step", 16, 1, 0, 0, 17);
        check("t5.done_cyc", done_cyc, 20);

        // Abort in SETTLE with five entries queued.
        push(1, 1, 1);
        kick(3);
        tick();
        check("t6.en", force_spike_en, 1);
        tick();
        check("t6.ts", time_step, 1);
        for (int i = 0; i < 5; i++) push(2, i, 0);
        check("t6.rdy", stim_ready, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6.busy", busy, 0);
        check("t6.done", done, 0);
        check("t6.en_ab", force_spike_en, 0);
        check("t6.cnt", step_count, 1);
        start = 1'b1; num_steps = 16'd1; drain_done = 1'b1;
        tick();
        start = 1'b0;
        tick();
        drain_done = 1'b0;
        check("t6.flushed", force_spike_en, 0);
        check("t6.busy2", busy, 1);
        push(2, 9, 1);
        run(3, 100);
        check("t6.nev", nev, 2);
        ev_is("t6.e0", 0, 0, 2, 9, 1);
        ev_is("t6.e1", 1, 1, 0, 0, 2);
        check("t6.done_cyc", done_cyc, 6);
        check("t6.terr", timeout_err, 0);
        check("t6.cnt2", step_count, 1);

        // Asynchronous reset mid-INJECT with three entries still queued.
        push(1, 1, 0); push(1, 2, 0); push(1, 3, 0); push(1, 4, 0);
        kick(1);
        tick();
        check("t7.en_pre", force_spike_en, 1);
        reset = 1'b1;
        #1;
        check("t7.en", force_spike_en, 0);
        check("t7.blk", force_spike_block_select, 0);
        check("t7.nrn", force_spike_neuron_select, 0);
        check("t7.ts", time_step, 0);
        check("t7.busy", busy, 0);
        check("t7.done", done, 0);
        check("t7.cnt", step_count, 0);
        check("t7.rdy", stim_ready, 1);
        tick();
        reset = 1'b0;
        push(3, 2, 1);
        kick(1);
        run(2, 100);
        check("t7.nev", nev, 2);
        ev_is("t7.e0", 0, 0, 3, 2, 1);
        check("t7.done_cyc", done_cyc, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
